// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO block: register offsets,
// the register enum and the default pin count.
package gpio_pkg;

    localparam logic [1:0] OFF_LED  = 2'b00;
    localparam logic [1:0] OFF_BTN  = 2'b01;
    localparam logic [1:0] OFF_SW   = 2'b10;
    localparam logic [1:0] OFF_EDGE = 2'b11;

    typedef enum logic [1:0] {
        REG_LED  = 2'b00,
        REG_BTN  = 2'b01,
        REG_SW   = 2'b10,
        REG_EDGE = 2'b11
    } gpio_reg_e;

    localparam int unsigned N_IO_DEFAULT = 4;

endpackage

// File: rtl/gpio_mmio_if.sv
// Core data-port bundle seen by the GPIO peripheral. Reads are same-cycle,
// so rdata/hit are combinational on the slave side.
interface gpio_mmio_if #(
    parameter int unsigned WIDTH = 64
) ();
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             we;
    logic             re;
    logic [WIDTH-1:0] rdata;
    logic             hit;

    modport master (output addr, output wdata, output we, output re,
                    input  rdata, input hit);
    modport slave  (input  addr, input wdata, input we, input re,
                    output rdata, output hit);
endinterface

// File: rtl/gpio_mmio_debouncer.sv
// Per-bit debouncer: 2-FF synchronizer, then a counter that must see the
// synchronized value differ from the stable value for DEBOUNCE_CYCLES
// consecutive cycles before the stable value follows it.
module gpio_mmio_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned W               = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] pin_i,
    output logic [W-1:0] stable_o,
    output logic [W-1:0] rise_o
);
    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]  s1_q;
    logic [W-1:0]  s2_q;
    logic [W-1:0]  stable_q;
    logic [W-1:0]  stable_d;
    logic [CW-1:0] cnt_q [W];
    logic [CW-1:0] cnt_d [W];

    // Next stable value and counter per bit; the counter restarts whenever the
    // input agrees with the stable value, so it cannot run past CNT_LAST.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(W); i++) begin
            cnt_d[i] = {CW{1'b0}};
            if (s2_q[i] == stable_q[i]) begin
                cnt_d[i] = {CW{1'b0}};
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = s2_q[i];
                cnt_d[i]    = {CW{1'b0}};
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Synchronizer, stable value and counters; reset discards any partial count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= {W{1'b0}};
            s2_q     <= {W{1'b0}};
            stable_q <= {W{1'b0}};
            for (int i = 0; i < int'(W); i++) begin
                cnt_q[i] <= {CW{1'b0}};
            end
        end else begin
            s1_q     <= pin_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            for (int i = 0; i < int'(W); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable_o = stable_q;
    // Rise is flagged on the same edge that stable goes 0->1.
    assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: LED register, debounced buttons/switches and sticky
// write-one-to-clear rising-edge flags for the buttons. 32-byte window at
// BASE_ADDR, four 8-byte registers selected by addr[4:3].
module gpio_mmio
    import gpio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 64,
    parameter logic [WIDTH-1:0] BASE_ADDR       = WIDTH'(64'h1000),
    parameter int unsigned      N_IO            = N_IO_DEFAULT,
    parameter int unsigned      DEBOUNCE_CYCLES = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    gpio_mmio_if.slave      bus,
    output logic [N_IO-1:0] led_o,
    input  logic [N_IO-1:0] btn_i,
    input  logic [N_IO-1:0] sw_i
);
    logic [N_IO-1:0] led_q,  led_d;
    logic [N_IO-1:0] edge_q, edge_d;
    logic [N_IO-1:0] btn_stable_s, btn_rise_s;
    logic [N_IO-1:0] sw_stable_s,  sw_rise_s;
    logic [N_IO-1:0] edge_clr_s;
    logic [N_IO-1:0] rd_reg_s;
    logic            hit_s;
    logic            wr_s;
    logic [1:0]      off_s;
    logic            unused_s;

    gpio_mmio_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(N_IO)) u_btn_db (
        .clk_i(clk_i), .rst_ni(rst_ni), .pin_i(btn_i),
        .stable_o(btn_stable_s), .rise_o(btn_rise_s)
    );

    gpio_mmio_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .W(N_IO)) u_sw_db (
        .clk_i(clk_i), .rst_ni(rst_ni), .pin_i(sw_i),
        .stable_o(sw_stable_s), .rise_o(sw_rise_s)
    );

    assign hit_s    = (bus.addr[WIDTH-1:5] == BASE_ADDR[WIDTH-1:5]);
    assign off_s    = bus.addr[4:3];
    assign wr_s     = bus.we & hit_s;
    // Upper store data, byte-lane bits and switch rises have no function here.
    assign unused_s = ^{bus.wdata[WIDTH-1:N_IO], bus.addr[2:0], sw_rise_s};

    // Register updates: LED store, W1C of edge flags; a new rise beats a clear.
    always_comb begin
        led_d      = led_q;
        edge_clr_s = {N_IO{1'b0}};
        if (wr_s) begin
            case (off_s)
                OFF_LED:  led_d      = bus.wdata[N_IO-1:0];
                OFF_EDGE: edge_clr_s = bus.wdata[N_IO-1:0];
                default:  led_d      = led_q;
            endcase
        end else begin
            led_d = led_q;
        end
        edge_d = (edge_q & ~edge_clr_s) | btn_rise_s;
    end

    // LED and edge-flag state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_q  <= {N_IO{1'b0}};
            edge_q <= {N_IO{1'b0}};
        end else begin
            led_q  <= led_d;
            edge_q <= edge_d;
        end
    end

    // Same-cycle read mux; no side effects on any register.
    always_comb begin
        rd_reg_s = {N_IO{1'b0}};
        if (bus.re && hit_s) begin
            case (gpio_reg_e'(off_s))
                REG_LED:  rd_reg_s = led_q;
                REG_BTN:  rd_reg_s = btn_stable_s;
                REG_SW:   rd_reg_s = sw_stable_s;
                REG_EDGE: rd_reg_s = edge_q;
                default:  rd_reg_s = {N_IO{1'b0}};
            endcase
        end else begin
            rd_reg_s = {N_IO{1'b0}};
        end
    end

    assign bus.rdata = {{(WIDTH-N_IO){1'b0}}, rd_reg_s};
    assign bus.hit   = hit_s;
    assign led_o     = led_q;

endmodule
